// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types and default timing for the Tetris input controller.
// Holds the move encoding consumed by tetris_fsm and the gravity-period helper.
package tetris_input_ctrl_pkg;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        ROR   = 3'd2,
        ROL   = 3'd3,
        DOWN  = 3'd4,
        NONE  = 3'd5
    } move_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } issue_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC = 16;
    localparam int unsigned DEF_DAS_TICKS    = 8;
    localparam int unsigned DEF_ARR_TICKS    = 2;
    localparam int unsigned DEF_SOFT_TICKS   = 2;
    localparam int unsigned DEF_GRAV_BASE    = 48;
    localparam int unsigned DEF_GRAV_STEP    = 4;

    // max(1, base - level*step), product saturated to 7 bits
    function automatic logic [6:0] grav_period(input logic [3:0] level,
                                               input logic [6:0] base,
                                               input logic [6:0] step);
        logic [10:0] prod;
        prod = 11'(level) * 11'(step);
        if (prod > 11'd127) prod = 11'd127;
        if (prod[6:0] >= base) return 7'd1;
        return base - prod[6:0];
    endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Button/tick/ack inputs and one-hot move outputs between the game FSM side and
// the input controller.
interface tetris_input_ctrl_if
    import tetris_input_ctrl_pkg::*;
();
    logic       btn_right;
    logic       btn_left;
    logic       btn_rr;
    logic       btn_rl;
    logic       btn_down;
    logic       tick;
    logic       play_en;
    logic [3:0] level;
    logic       ack;
    logic       right;
    logic       left;
    logic       rr;
    logic       rl;
    logic       down;
    move_t      move_o;
    logic       busy;

    modport master (
        output btn_right, btn_left, btn_rr, btn_rl, btn_down, tick, play_en, level, ack,
        input  right, left, rr, rl, down, move_o, busy
    );

    modport slave (
        input  btn_right, btn_left, btn_rr, btn_rl, btn_down, tick, play_en, level, ack,
        output right, left, rr, rl, down, move_o, busy
    );
endinterface

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the level flips only
// after DEBOUNCE_CYC consecutive cycles of the new synchronised value.
module tetris_input_ctrl_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Turns debounced buttons, auto-repeat and gravity into single one-hot move
// requests held until the game FSM acknowledges them.
module tetris_input_ctrl
    import tetris_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned DAS_TICKS    = DEF_DAS_TICKS,
    parameter int unsigned ARR_TICKS    = DEF_ARR_TICKS,
    parameter int unsigned SOFT_TICKS   = DEF_SOFT_TICKS,
    parameter int unsigned GRAV_BASE    = DEF_GRAV_BASE,
    parameter int unsigned GRAV_STEP    = DEF_GRAV_STEP
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tetris_input_ctrl_if.slave io_bus
);
    localparam int unsigned NBTN = 5;

    // Bit order everywhere: 0 right, 1 left, 2 rr, 3 rl, 4 down (also priority order)
    logic [NBTN-1:0] w_raw, w_db, w_lvl, w_rise, w_set, w_pend, w_pend_d, w_grant;
    logic [NBTN-1:0] r_lvl, r_pend;
    logic            w_both;

    logic [7:0] r_hold [2];
    logic [7:0] w_hold_d [2];
    logic [1:0] r_das, w_das_d, w_rep_set;
    logic [7:0] r_soft, w_soft_d;
    logic       w_soft_set;

    logic [6:0] r_grav, w_grav_d, w_period;
    logic       w_grav_set;

    issue_state_t r_state, w_state_d;
    move_t        r_move, w_move_d;

    assign w_raw = {io_bus.btn_down, io_bus.btn_rl, io_bus.btn_rr,
                    io_bus.btn_left, io_bus.btn_right};

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        tetris_input_ctrl_btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_btn  (w_raw[gi]),
            .o_level(w_db[gi])
        );
    end

    // Left+right together cancel; releasing one looks like a fresh press of the other
    assign w_both = w_db[0] & w_db[1];
    assign w_lvl  = {w_db[4:2], w_db[1] & ~w_db[0], w_db[0] & ~w_db[1]};
    assign w_rise = w_lvl & ~r_lvl;

    always_comb begin
        w_rep_set  = '0;
        w_das_d    = r_das;
        w_soft_set = 1'b0;
        w_soft_d   = r_soft;
        for (int i = 0; i < 2; i++) begin
            w_hold_d[i] = r_hold[i];
            if (!w_lvl[i] || w_rise[i]) begin
                w_hold_d[i] = '0;
                w_das_d[i]  = 1'b0;
            end else if (io_bus.tick) begin
                if (!r_das[i] && (r_hold[i] + 8'd1) == 8'(DAS_TICKS)) begin
                    w_rep_set[i] = 1'b1;
                    w_das_d[i]   = 1'b1;
                    w_hold_d[i]  = '0;
                end else if (r_das[i] && (r_hold[i] + 8'd1) == 8'(ARR_TICKS)) begin
                    w_rep_set[i] = 1'b1;
                    w_hold_d[i]  = '0;
                end else begin
                    w_hold_d[i] = r_hold[i] + 8'd1;
                end
            end
        end
        if (!w_lvl[4] || w_rise[4]) begin
            w_soft_d = '0;
        end else if (io_bus.tick) begin
            if ((r_soft + 8'd1) == 8'(SOFT_TICKS)) begin
                w_soft_set = 1'b1;
                w_soft_d   = '0;
            end else begin
                w_soft_d = r_soft + 8'd1;
            end
        end
    end

    assign w_period   = grav_period(io_bus.level, 7'(GRAV_BASE), 7'(GRAV_STEP));
    assign w_grav_set = io_bus.play_en & io_bus.tick & ((r_grav + 7'd1) >= w_period);

    always_comb begin
        w_grav_d = r_grav;
        if (!io_bus.play_en || w_grav_set || w_grant[4]) begin
            w_grav_d = '0;
        end else if (io_bus.tick) begin
            w_grav_d = r_grav + 7'd1;
        end
    end

    // Sets this cycle are visible to the arbiter immediately (one-cycle latency)
    always_comb begin
        w_set = {w_rise[4] | w_soft_set | w_grav_set, w_rise[3], w_rise[2],
                 w_rise[1] | w_rep_set[1], w_rise[0] | w_rep_set[0]};
        w_pend = r_pend | w_set;
        if (w_both) w_pend[1:0] = 2'b00;

        w_grant   = '0;
        w_state_d = r_state;
        w_move_d  = r_move;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.play_en && (|w_pend)) begin
                    w_state_d = S_ISSUE;
                    if (w_pend[0]) begin
                        w_grant  = 5'b00001;
                        w_move_d = RIGHT;
                    end else if (w_pend[1]) begin
                        w_grant  = 5'b00010;
                        w_move_d = LEFT;
                    end else if (w_pend[2]) begin
                        w_grant  = 5'b00100;
                        w_move_d = ROR;
                    end else if (w_pend[3]) begin
                        w_grant  = 5'b01000;
                        w_move_d = ROL;
                    end else begin
                        w_grant  = 5'b10000;
                        w_move_d = DOWN;
                    end
                end
            end
            S_ISSUE: begin
                if (!io_bus.play_en || io_bus.ack) begin
                    w_move_d  = NONE;
                    w_state_d = S_GAP;
                end
            end
            S_GAP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_move_d  = NONE;
                w_state_d = S_IDLE;
            end
        endcase

        w_pend_d = io_bus.play_en ? (w_pend & ~w_grant) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lvl     <= '0;
            r_pend    <= '0;
            r_hold[0] <= '0;
            r_hold[1] <= '0;
            r_das     <= '0;
            r_soft    <= '0;
            r_grav    <= '0;
            r_state   <= S_IDLE;
            r_move    <= NONE;
        end else begin
            r_lvl     <= w_lvl;
            r_pend    <= w_pend_d;
            r_hold[0] <= w_hold_d[0];
            r_hold[1] <= w_hold_d[1];
            r_das     <= w_das_d;
            r_soft    <= w_soft_d;
            r_grav    <= w_grav_d;
            r_state   <= w_state_d;
            r_move    <= w_move_d;
        end
    end

    assign io_bus.right  = (r_move == RIGHT);
    assign io_bus.left   = (r_move == LEFT);
    assign io_bus.rr     = (r_move == ROR);
    assign io_bus.rl     = (r_move == ROL);
    assign io_bus.down   = (r_move == DOWN);
    assign io_bus.move_o = r_move;
    assign io_bus.busy   = (r_state == S_ISSUE);

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: stimulus queues expected moves, a
// monitor pops and compares each new request as it is presented.
module tb_tetris_input_ctrl;
    import tetris_input_ctrl_pkg::*;

    typedef struct {
        move_t mv;
        int    cyc;
        int    tk;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   tick_cnt = 0;
    bit   tick_en = 1'b0;
    bit   ack_auto = 1'b1;
    int   c0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_pb = 1'b0;
    exp_t mon_e;

    tetris_input_ctrl_if bus ();

    tetris_input_ctrl #(
        .DEBOUNCE_CYC(4),
        .DAS_TICKS   (3),
        .ARR_TICKS   (1),
        .SOFT_TICKS  (2),
        .GRAV_BASE   (10),
        .GRAV_STEP   (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_move(input move_t m, input int c, input int t);
        exp_t e;
        e.mv  = m;
        e.cyc = c;
        e.tk  = t;
        sb_q.push_back(e);
    endtask

    task automatic play_pulse();
        bus.play_en = 1'b0;
        step(1);
        bus.play_en = 1'b1;
    endtask

    // Monitor: a rising busy marks a newly presented request
    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1 && mon_pb !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got move %0d, expected none (cycle %0d)",
                             int'(bus.move_o), cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("req_move", int'(bus.move_o), int'(mon_e.mv));
                    check("req_lines", int'({bus.down, bus.rl, bus.rr, bus.left, bus.right}),
                          1 << int'(mon_e.mv));
                    if (mon_e.cyc >= 0) check("req_cycle", cyc, mon_e.cyc);
                    if (mon_e.tk >= 0) check("req_tick", tick_cnt, mon_e.tk);
                end
            end
            mon_pb = bus.busy;
        end
    end

    // Responder: ack one clock after a request appears
    initial begin
        bus.ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ack = ack_auto && (bus.busy === 1'b1) && !bus.ack;
        end
    end

    // Frame tick every 8 clocks while enabled
    initial begin
        int div;
        div = 0;
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                if (div == 7) begin
                    bus.tick = 1'b1;
                    tick_cnt++;
                    div = 0;
                end else begin
                    bus.tick = 1'b0;
                    div++;
                end
            end else begin
                bus.tick = 1'b0;
                div = 0;
            end
        end
    end

    initial begin
        bus.btn_right = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_rr    = 1'b0;
        bus.btn_rl    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.play_en   = 1'b1;
        bus.level     = 4'd0;

        step(3);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_move", int'(bus.move_o), int'(NONE));
        check("rst_lines", int'({bus.down, bus.rl, bus.rr, bus.left, bus.right}), 0);
        rst = 1'b0;
        step(2);

        // Glitch then hold on rotate-right: one ROR, 7 cycles after hold begins
        bus.btn_rr = 1'b1;
        step(2);
        bus.btn_rr = 1'b0;
        step(3);
        c0 = cyc;
        bus.btn_rr = 1'b1;
        expect_move(ROR, c0 + 7, -1);
        step(20);
        bus.btn_rr = 1'b0;
        step(12);

        // Left held for 6 ticks: press, then DAS at 3, ARR every tick
        play_pulse();
        tick_cnt = 0;
        c0 = cyc;
        bus.btn_left = 1'b1;
        expect_move(LEFT, c0 + 7, 0);
        step(10);
        tick_cnt = 0;
        tick_en = 1'b1;
        for (int k = 3; k <= 6; k++) expect_move(LEFT, -1, k);
        step(52);
        tick_en = 1'b0;
        bus.btn_left = 1'b0;
        step(12);

        // Left and right together: nothing; release right -> one left
        play_pulse();
        bus.btn_left = 1'b1;
        bus.btn_right = 1'b1;
        step(10);
        tick_cnt = 0;
        tick_en = 1'b1;
        step(36);
        c0 = cyc;
        bus.btn_right = 1'b0;
        expect_move(LEFT, c0 + 7, -1);
        step(16);
        tick_en = 1'b0;
        bus.btn_left = 1'b0;
        step(12);

        // Gravity at level 0: period 10 ticks
        play_pulse();
        bus.level = 4'd0;
        tick_cnt = 0;
        tick_en = 1'b1;
        expect_move(DOWN, -1, 10);
        expect_move(DOWN, -1, 20);
        step(164);
        tick_en = 1'b0;
        step(4);

        // Gravity at level 3: period clamps to 1 tick
        bus.level = 4'd3;
        play_pulse();
        tick_cnt = 0;
        tick_en = 1'b1;
        for (int k = 1; k <= 4; k++) expect_move(DOWN, -1, k);
        step(36);
        tick_en = 1'b0;
        bus.level = 4'd0;
        step(4);

        // Right and down set together: right first, down after gap + idle
        c0 = cyc;
        bus.btn_right = 1'b1;
        bus.btn_down = 1'b1;
        expect_move(RIGHT, c0 + 7, -1);
        expect_move(DOWN, c0 + 10, -1);
        step(14);
        bus.btn_right = 1'b0;
        bus.btn_down = 1'b0;
        step(12);

        // play_en dropped while a request is presented: line drops, no ack
        ack_auto = 1'b0;
        step(1);
        c0 = cyc;
        bus.btn_rr = 1'b1;
        expect_move(ROR, c0 + 7, -1);
        step(8);
        check("issue_busy", int'(bus.busy), 1);
        bus.play_en = 1'b0;
        step(1);
        check("playoff_busy", int'(bus.busy), 0);
        check("playoff_move", int'(bus.move_o), int'(NONE));
        bus.play_en = 1'b1;
        bus.btn_rr = 1'b0;
        step(12);

        // Reset mid-handshake with ROL still pending: both dropped
        c0 = cyc;
        bus.btn_rr = 1'b1;
        bus.btn_rl = 1'b1;
        expect_move(ROR, c0 + 7, -1);
        step(8);
        bus.btn_rr = 1'b0;
        bus.btn_rl = 1'b0;
        check("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        step(1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_move", int'(bus.move_o), int'(NONE));
        check("midrst_lines", int'({bus.down, bus.rl, bus.rr, bus.left, bus.right}), 0);
        rst = 1'b0;
        ack_auto = 1'b1;
        step(20);

        check("queue_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
